// File: rtl/usbl_rx_pkg.sv
// Shared constants and FSM state type for the USBL hydrophone receive path.
package usbl_rx_pkg;

  localparam int unsigned DATA_W         = 16;
  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned HOLDOFF_CYCLES = 190;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PENDING = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_holdoff_timer.sv
// Down-counter that enforces the minimum spacing between frame release strobes.
module rx_holdoff_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/rx_frame_assembler.sv
// Collects one sample per hydrophone channel (ch0..ch3 in order) and releases
// the completed frame on rx1..rx4 with a one-cycle enable, rate-limited by a holdoff.
module rx_frame_assembler #(
  parameter int unsigned DATA_W         = usbl_rx_pkg::DATA_W,
  parameter int unsigned HOLDOFF_CYCLES = usbl_rx_pkg::HOLDOFF_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [1:0]               s_chan,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     clear_err,
  output logic signed [DATA_W-1:0] rx1,
  output logic signed [DATA_W-1:0] rx2,
  output logic signed [DATA_W-1:0] rx3,
  output logic signed [DATA_W-1:0] rx4,
  output logic                     enable,
  output logic                     frame_err,
  output logic [7:0]               drop_cnt
);

  import usbl_rx_pkg::*;

  localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  rx_state_e               state_q, state_d;
  logic [1:0]              expect_q, expect_d;
  logic signed [DATA_W-1:0] shadow_q [NUM_CH];
  logic signed [DATA_W-1:0] shadow_d [NUM_CH];
  logic signed [DATA_W-1:0] rx_q     [NUM_CH];
  logic signed [DATA_W-1:0] rx_d     [NUM_CH];
  logic                    enable_q, enable_d;
  logic                    frame_err_q, frame_err_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    accept;
  logic                    drop_evt;
  logic                    err_set;
  logic                    hold_load;
  logic                    hold_expired;

  // Ready is a pure decode of the state so the upstream source sees backpressure immediately.
  assign s_ready  = (state_q != PENDING);
  assign accept   = s_valid && s_ready;
  assign drop_evt = s_valid && !s_ready;

  rx_holdoff_timer #(
    .CNT_W (CNT_W)
  ) u_holdoff (
    .clock    (clock),
    .reset    (reset),
    .load     (hold_load),
    .load_val (CNT_W'(HOLDOFF_CYCLES - 1)),
    .expired  (hold_expired)
  );

  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    shadow_d  = shadow_q;
    rx_d      = rx_q;
    enable_d  = 1'b0;
    err_set   = 1'b0;
    hold_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_chan == 2'd0) begin
            shadow_d[0] = s_data;
            expect_d    = 2'd1;
            state_d     = COLLECT;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (s_chan == expect_q) begin
            shadow_d[expect_q] = s_data;
            expect_d           = expect_q + 2'd1;
            if (expect_q == 2'd3) begin
              state_d = PENDING;
            end
          end else if (s_chan == 2'd0) begin
            // A fresh ch0 mid-frame is treated as the start of a new frame.
            err_set     = 1'b1;
            shadow_d[0] = s_data;
            expect_d    = 2'd1;
          end else begin
            err_set  = 1'b1;
            expect_d = 2'd0;
            state_d  = IDLE;
          end
        end
      end
      PENDING: begin
        if (hold_expired) begin
          rx_d      = shadow_q;
          enable_d  = 1'b1;
          hold_load = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        expect_d = 2'd0;
      end
    endcase
  end

  // New events take priority over a simultaneous clear.
  always_comb begin
    frame_err_d = frame_err_q;
    if (err_set) begin
      frame_err_d = 1'b1;
    end else if (clear_err) begin
      frame_err_d = 1'b0;
    end
    drop_cnt_d = drop_cnt_q;
    if (clear_err) begin
      drop_cnt_d = drop_evt ? 8'd1 : 8'd0;
    end else if (drop_evt && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      expect_q    <= 2'd0;
      enable_q    <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= 8'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        rx_q[i]     <= '0;
      end
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      enable_q    <= enable_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q  <= drop_cnt_d;
      shadow_q    <= shadow_d;
      rx_q        <= rx_d;
    end
  end

  assign rx1       = rx_q[0];
  assign rx2       = rx_q[1];
  assign rx3       = rx_q[2];
  assign rx4       = rx_q[3];
  assign enable    = enable_q;
  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Scoreboard bench for rx_frame_assembler: frames are queued as driven and popped on enable.
module tb_rx_frame_assembler;

  typedef struct packed {
    logic signed [15:0] r1;
    logic signed [15:0] r2;
    logic signed [15:0] r3;
    logic signed [15:0] r4;
  } frame_t;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [1:0]         s_chan = 2'd0;
  logic signed [15:0] s_data = '0;
  logic               clear_err = 1'b0;
  logic signed [15:0] rx1, rx2, rx3, rx4;
  logic               enable;
  logic               frame_err;
  logic [7:0]         drop_cnt;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     en_cnt = 0;
  int     en_cyc = 0;
  int     en_cyc_prev = 0;
  int     last_send_cyc = 0;
  frame_t sb[$];
  logic [63:0] prev_rx = '0;
  logic        prev_rst = 1'b0;

  rx_frame_assembler dut (
    .clock     (clock),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_chan    (s_chan),
    .s_data    (s_data),
    .clear_err (clear_err),
    .rx1       (rx1),
    .rx2       (rx2),
    .rx3       (rx3),
    .rx4       (rx4),
    .enable    (enable),
    .frame_err (frame_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every enable and checks rx holds otherwise.
  always @(negedge clock) begin
    frame_t f;
    if (reset && enable) begin
      en_cnt++;
      en_cyc_prev = en_cyc;
      en_cyc      = cyc;
      check_eq("sb_pending", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        f = sb.pop_front();
        check_eq("rx1", rx1, f.r1);
        check_eq("rx2", rx2, f.r2);
        check_eq("rx3", rx3, f.r3);
        check_eq("rx4", rx4, f.r4);
      end
    end
    if (reset && prev_rst && !enable) begin
      check_eq("rx_hold", {rx1, rx2, rx3, rx4}, prev_rx);
    end
    prev_rx  = {rx1, rx2, rx3, rx4};
    prev_rst = reset;
  end

  task automatic send(input logic [1:0] ch, input logic signed [15:0] d);
    s_valid = 1'b1;
    s_chan  = ch;
    s_data  = d;
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    last_send_cyc = cyc;
  endtask

  task automatic send_frame(input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic signed [15:0] c, input logic signed [15:0] d);
    frame_t f;
    send(2'd0, a);
    send(2'd1, b);
    send(2'd2, c);
    send(2'd3, d);
    f.r1 = a; f.r2 = b; f.r3 = c; f.r4 = d;
    sb.push_back(f);
  endtask

  task automatic wait_en(input int budget);
    int start = en_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (en_cnt != start) return;
    end
    check_eq("enable_timeout", en_cnt - start, 1);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clock);
    #1;
    clear_err = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_enable"}, enable, 0);
    check_eq({tag, "_rx"}, {rx1, rx2, rx3, rx4}, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_drop"}, drop_cnt, 0);
    check_eq({tag, "_ready"}, s_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_reset_state("rst0");
    reset = 1'b1;
    @(negedge clock);

    // First frame after reset: released one cycle after ch3 with no holdoff wait
    send_frame(16'sd5004, 16'sd9890, 16'sd14545, 16'sd18858);
    wait_en(10);
    check_eq("lat_first", en_cyc - last_send_cyc, 1);
    check_eq("ferr_clean", frame_err, 0);

    // Back-to-back frame is held off; ready drops and refused samples are counted
    send_frame(-16'sd2550, -16'sd2550, -16'sd2550, -16'sd2550);
    s_valid = 1'b1; s_chan = 2'd0; s_data = 16'sd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check_eq("ready_pending", s_ready, 0);
      @(posedge clock);
      #1;
    end
    s_valid = 1'b0;
    check_eq("drop_20", drop_cnt, 20);
    wait_en(250);
    check_eq("holdoff_gap", en_cyc - en_cyc_prev, 190);
    check_eq("ready_after", s_ready, 1);

    // Skipped channel: error, partial frame discarded
    send(2'd0, 16'sd1);
    send(2'd1, 16'sd2);
    send(2'd3, 16'sd3);
    check_eq("ferr_skip", frame_err, 1);
    send_frame(16'sd32744, 16'sd32744, 16'sd32744, 16'sd32744);
    wait_en(250);
    check_eq("ferr_sticky", frame_err, 1);
    pulse_clear();
    check_eq("ferr_cleared", frame_err, 0);
    check_eq("drop_cleared", drop_cnt, 0);

    // Early ch0 restarts the frame
    send(2'd0, 16'sd1);
    send(2'd1, 16'sd2);
    send_frame(-16'sd82, 16'sd3, 16'sd4, 16'sd5);
    check_eq("ferr_restart", frame_err, 1);
    wait_en(250);
    pulse_clear();

    // Drop counter saturation across two pending periods
    for (int k = 0; k < 2; k++) begin
      send_frame(16'sd7, 16'sd7, 16'sd7, 16'sd7);
      s_valid = 1'b1; s_chan = 2'd0; s_data = 16'sd7;
      wait_en(250);
    end
    s_valid = 1'b0;
    check_eq("drop_sat", drop_cnt, 255);
    check_eq("ferr_none", frame_err, 0);
    pulse_clear();
    check_eq("drop_clr", drop_cnt, 0);

    // Clear coinciding with a drop, then with a sequence error
    send_frame(16'sd100, 16'sd200, 16'sd300, 16'sd400);
    s_valid = 1'b1; clear_err = 1'b1;
    @(posedge clock);
    #1;
    s_valid = 1'b0; clear_err = 1'b0;
    check_eq("clr_vs_drop", drop_cnt, 1);
    wait_en(250);
    s_valid = 1'b1; s_chan = 2'd2; s_data = 16'sd9; clear_err = 1'b1;
    @(posedge clock);
    #1;
    s_valid = 1'b0; clear_err = 1'b0;
    check_eq("clr_vs_err", frame_err, 1);
    check_eq("clr_vs_err_drop", drop_cnt, 0);
    pulse_clear();

    // Reset mid-frame discards it; next frame is released immediately
    send(2'd0, 16'sd11);
    send(2'd1, 16'sd12);
    send(2'd2, 16'sd13);
    reset = 1'b0;
    @(negedge clock);
    check_reset_state("rst_mid");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send_frame(16'sd21, -16'sd22, 16'sd23, -16'sd24);
    wait_en(10);
    check_eq("lat_after_rst", en_cyc - last_send_cyc, 1);
    repeat (5) @(negedge clock);
    check_eq("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
